clk_div_monitor: RTL

Self-checking consumer of the `clock_gen` divided-clock outputs, in the same `clk_in` domain. On command it measures the period and high time of one selected divided clock in `clk_in` cycles over several consecutive periods, and reports pass/fail against the nominal division ratio. It sits directly downstream of `clock_gen` and serves as the lab's on-chip divider checker.

---
 rtl/clk_mon_pkg.sv | 35 +++
 rtl/edge_detect.sv | 27 ++
 rtl/clk_div_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    DONE
  } state_e;

  // Select encodings into div_clks
  localparam logic [2:0] DIV_IDX_2  = 3'd0;
  localparam logic [2:0] DIV_IDX_4  = 3'd1;
  localparam logic [2:0] DIV_IDX_8  = 3'd2;
  localparam logic [2:0] DIV_IDX_16 = 3'd3;
  localparam logic [2:0] DIV_IDX_28 = 3'd4;
  localparam logic [2:0] DIV_IDX_5  = 3'd5;

  localparam int unsigned NUM_DIV = 6;

  // Nominal period of each divided clock, in clk_in cycles
  localparam int unsigned EXP_PERIOD [NUM_DIV] = '{2, 4, 8, 16, 28, 5};

  localparam logic [3:0] ERR_SAT = 4'd15;

  function automatic logic sel_valid(input logic [2:0] idx);
    return idx <= DIV_IDX_5;
  endfunction

  function automatic int unsigned exp_period(input logic [2:0] idx);
    if (sel_valid(idx)) return EXP_PERIOD[idx];
    return 0;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers the selected divided clock and flags its rising/falling edges.
module edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic sig,
  output logic cur,
  output logic rise,
  output logic fall
);

  logic prv;

  // Two-deep sample history of the monitored clock
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cur <= 1'b0;
      prv <= 1'b0;
    end else begin
      cur <= sig;
      prv <= cur;
    end
  end

  assign rise = cur & ~prv;
  assign fall = ~cur & prv;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of one selected divided clock and checks
// it against the nominal division ratio over NUM_PER periods.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int NUM_PER = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [5:0]       div_clks,
  input  logic [2:0]       sel,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             pass,
  output logic             timeout,
  output logic [3:0]       err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LAST_PER = 4'(NUM_PER - 1);

  state_e           state, state_d;
  logic [2:0]       sel_q, src_idx;
  logic             src_bit, cur, rise, fall;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [3:0]       per_idx, err_nxt;
  logic             fall_seen;
  logic             arm_rise, meas_rise, cnt_sat, sat_hit, last_per, mismatch;

  // Source select: follow the live sel while idle so the sampler already
  // holds the new clock in the cycle the run starts.
  always_comb begin
    src_idx = (state == IDLE) ? sel : sel_q;
    case (src_idx)
      DIV_IDX_2:  src_bit = div_clks[0];
      DIV_IDX_4:  src_bit = div_clks[1];
      DIV_IDX_8:  src_bit = div_clks[2];
      DIV_IDX_16: src_bit = div_clks[3];
      DIV_IDX_28: src_bit = div_clks[4];
      DIV_IDX_5:  src_bit = div_clks[5];
      default:    src_bit = 1'b0;
    endcase
  end

  edge_detect u_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .sig    (src_bit),
    .cur    (cur),
    .rise   (rise),
    .fall   (fall)
  );

  // Next-state and event decode. In the first ARM cycle prv still holds the
  // previously selected clock, so a rise there is not trusted.
  always_comb begin
    cnt_sat   = (cnt == CNT_MAX);
    arm_rise  = (state == ARM) && rise && (cnt != '0);
    meas_rise = (state == MEAS) && rise;
    sat_hit   = ((state == ARM) && !arm_rise && cnt_sat) ||
                ((state == MEAS) && !rise && cnt_sat);
    last_per  = meas_rise && (per_idx == LAST_PER);
    mismatch  = meas_rise && (cnt != CNT_W'(exp_period(sel_q)));
    err_nxt   = (mismatch && (err_cnt != ERR_SAT)) ? err_cnt + 4'd1 : err_cnt;
    state_d   = state;
    case (state)
      IDLE: if (start) state_d = sel_valid(sel) ? ARM : DONE;
      ARM: begin
        if (arm_rise)     state_d = MEAS;
        else if (sat_hit) state_d = DONE;
      end
      MEAS: if (last_per || sat_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Counters, comparator and result registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sel_q     <= '0;
      cnt       <= '0;
      hcnt      <= '0;
      per_idx   <= '0;
      fall_seen <= 1'b0;
      period    <= '0;
      high_time <= '0;
      err_cnt   <= '0;
      timeout   <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel_q   <= sel;
          cnt     <= '0;
          hcnt    <= '0;
          per_idx <= '0;
          timeout <= 1'b0;
          pass    <= 1'b0;
          err_cnt <= sel_valid(sel) ? 4'd0 : ERR_SAT;
        end
        ARM: begin
          if (arm_rise) begin
            cnt       <= CNT_ONE;
            hcnt      <= CNT_ONE;
            fall_seen <= 1'b0;
          end else if (!cnt_sat) begin
            cnt <= cnt + CNT_ONE;
          end
          if (sat_hit) timeout <= 1'b1;
        end
        MEAS: begin
          if (rise) begin
            period    <= cnt;
            high_time <= hcnt;
            err_cnt   <= err_nxt;
            per_idx   <= per_idx + 4'd1;
            cnt       <= CNT_ONE;
            hcnt      <= CNT_ONE;
            fall_seen <= 1'b0;
            if (last_per) pass <= (err_nxt == 4'd0);
          end else begin
            if (!cnt_sat) cnt <= cnt + CNT_ONE;
            if (cur && !fall_seen && (hcnt != CNT_MAX)) hcnt <= hcnt + CNT_ONE;
            if (fall) fall_seen <= 1'b1;
            if (sat_hit) timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
